// File: rtl/smi_request_steer_x3.sv
// Steers whole SMI request frames from one input to one of three banks by the header source ID.
// Each bank has a 2-entry output FIFO; frames with ID 3 are discarded and counted.
module smi_request_steer_x3 #(
  parameter int unsigned FlitWidth = 8,
  parameter int unsigned TagLsb    = 26,
  parameter int unsigned DropCntW  = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   smiReqInReady,
  input  logic [7:0]             smiReqInEofc,
  input  logic [FlitWidth*8-1:0] smiReqInData,
  output logic                   smiReqInStop,
  output logic                   smiReqAOutReady,
  output logic [7:0]             smiReqAOutEofc,
  output logic [FlitWidth*8-1:0] smiReqAOutData,
  input  logic                   smiReqAOutStop,
  output logic                   smiReqBOutReady,
  output logic [7:0]             smiReqBOutEofc,
  output logic [FlitWidth*8-1:0] smiReqBOutData,
  input  logic                   smiReqBOutStop,
  output logic                   smiReqCOutReady,
  output logic [7:0]             smiReqCOutEofc,
  output logic [FlitWidth*8-1:0] smiReqCOutData,
  input  logic                   smiReqCOutStop,
  output logic [DropCntW-1:0]    dropCount
);

  localparam int unsigned DW = FlitWidth * 8;

  localparam logic [1:0] StHead = 2'd0;
  localparam logic [1:0] StBody = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [DropCntW-1:0] drop_q, drop_d;
  logic                init_q;

  logic [1:0]    cnt_q [3];
  logic [1:0]    cnt_d [3];
  logic [2:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [7:0]    eofc_mem_q [3][2];
  logic [DW-1:0] data_mem_q [3][2];

  logic [2:0]    out_stop;
  logic [2:0]    push;
  // Bit 3 stays 0 so the discard ID can index these without a range check.
  logic [3:0]    full, pop;
  logic [2:0]    head_ready;
  logic [7:0]    head_eofc [3];
  logic [DW-1:0] head_data [3];

  logic [1:0] hdr_sel, cur_sel;
  logic       stop_c, in_xfer;

  assign out_stop = {smiReqCOutStop, smiReqBOutStop, smiReqAOutStop};
  assign hdr_sel  = smiReqInData[TagLsb+1:TagLsb];
  assign cur_sel  = (state_q == StHead) ? hdr_sel : sel_q;

  always_comb begin
    full = '0;
    pop  = '0;
    for (int b = 0; b < 3; b++) begin
      head_ready[b] = (cnt_q[b] != 2'd0);
      full[b]       = (cnt_q[b] == 2'd2);
      pop[b]        = head_ready[b] & ~out_stop[b];
      head_eofc[b]  = head_ready[b] ? eofc_mem_q[b][rd_ptr_q[b]] : '0;
      head_data[b]  = head_ready[b] ? data_mem_q[b][rd_ptr_q[b]] : '0;
    end
  end

  always_comb begin
    stop_c = 1'b0;
    case (state_q)
      StHead:  stop_c = (hdr_sel != 2'd3) & full[hdr_sel] & ~pop[hdr_sel];
      StBody:  stop_c = full[sel_q] & ~pop[sel_q];
      default: stop_c = 1'b0;
    endcase
  end

  // Input stays stopped until the first clock after reset release.
  assign smiReqInStop = ~init_q | stop_c;
  assign in_xfer      = smiReqInReady & ~smiReqInStop;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    drop_d  = drop_q;
    if (in_xfer) begin
      case (state_q)
        StHead: begin
          sel_d = hdr_sel;
          if (hdr_sel == 2'd3 && drop_q != {DropCntW{1'b1}}) drop_d = drop_q + 1'b1;
          if (smiReqInEofc != 8'd0)  state_d = StHead;
          else if (hdr_sel == 2'd3)  state_d = StDrop;
          else                       state_d = StBody;
        end
        default: if (smiReqInEofc != 8'd0) state_d = StHead;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int b = 0; b < 3; b++) begin
      push[b]     = in_xfer & (state_q != StDrop) & (cur_sel == 2'(b));
      cnt_d[b]    = cnt_q[b] + 2'(push[b]) - 2'(pop[b]);
      if (push[b]) wr_ptr_d[b] = ~wr_ptr_q[b];
      if (pop[b])  rd_ptr_d[b] = ~rd_ptr_q[b];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= StHead;
      sel_q    <= 2'd0;
      drop_q   <= '0;
      init_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int b = 0; b < 3; b++) cnt_q[b] <= 2'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      drop_q   <= drop_d;
      init_q   <= 1'b1;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      for (int b = 0; b < 3; b++) cnt_q[b] <= cnt_d[b];
    end
  end

  // Storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (push[b]) begin
        eofc_mem_q[b][wr_ptr_q[b]] <= smiReqInEofc;
        data_mem_q[b][wr_ptr_q[b]] <= smiReqInData;
      end
    end
  end

  assign smiReqAOutReady = head_ready[0];
  assign smiReqAOutEofc  = head_eofc[0];
  assign smiReqAOutData  = head_data[0];
  assign smiReqBOutReady = head_ready[1];
  assign smiReqBOutEofc  = head_eofc[1];
  assign smiReqBOutData  = head_data[1];
  assign smiReqCOutReady = head_ready[2];
  assign smiReqCOutEofc  = head_eofc[2];
  assign smiReqCOutData  = head_data[2];
  assign dropCount       = drop_q;

endmodule
